// File: rtl/seg_scan_pkg.sv
// ============================================================================
// seg_scan_pkg : shared types and constants for the segment scan controller
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

  typedef enum logic [1:0] {
    BLANK_A = 2'd0,
    SHOW_A  = 2'd1,
    BLANK_B = 2'd2,
    SHOW_B  = 2'd3
  } scan_state_t;

  localparam int DEF_DWELL_CYCLES = 48000;
  localparam int DEF_BLANK_CYCLES = 480;

  localparam logic SEL_SWITCH1 = 1'b1;
  localparam logic SEL_SWITCH2 = 1'b0;

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// ============================================================================
// seg_scan_ctrl_if : scan enable in, mux select / anode enables / strobe out
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_scan_ctrl_if;
  logic en;
  logic select;
  logic anode_a_n;
  logic anode_b_n;
  logic digit_strobe;

  modport master (
    input  en,
    output select,
    output anode_a_n,
    output anode_b_n,
    output digit_strobe
  );

  modport slave (
    output en,
    input  select,
    input  anode_a_n,
    input  anode_b_n,
    input  digit_strobe
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_ctrl_timer.sv
// ============================================================================
// scan_timer : enabled up-counter with sync clear and runtime terminal count
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_timer #(
  parameter int CNT_W = 17
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en_i,
  input  wire logic             clr_i,
  input  wire logic [CNT_W-1:0] limit_i,
  output logic                  tc_o,
  output logic                  zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o   = (cnt_q == limit_i);
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : time-multiplexed two-digit scan with optional blanking gaps
//                 (blanking compiled in when macro BLANK_EN is defined)
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int CNT_W        = 17
) (
  input  wire logic        clk,
  input  wire logic        reset,
  seg_scan_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_CYCLES - 1);
`ifdef BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);
  localparam scan_state_t      RST_STATE = BLANK_A;
`else
  localparam scan_state_t      RST_STATE = SHOW_A;
`endif

  if (DWELL_CYCLES < 2) begin : g_chk_dwell
    $error("seg_scan_ctrl: DWELL_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_chk_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be >= 1");
  end
  if ((longint'(DWELL_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(BLANK_CYCLES) >= (longint'(1) << CNT_W))) begin : g_chk_width
    $error("seg_scan_ctrl: CNT_W too small for DWELL_CYCLES/BLANK_CYCLES");
  end

  scan_state_t      state_q;
  scan_state_t      state_d;
  logic [CNT_W-1:0] limit;
  logic             tc;
  logic             cnt_zero;
  logic             advance;
  logic             show;

  assign show    = (state_q == SHOW_A) || (state_q == SHOW_B);
  assign advance = bus.en && tc;

`ifdef BLANK_EN
  assign limit = show ? DWELL_LIM : BLANK_LIM;
`else
  assign limit = DWELL_LIM;
`endif

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en_i    (bus.en),
    .clr_i   (advance),
    .limit_i (limit),
    .tc_o    (tc),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
`ifdef BLANK_EN
        BLANK_A: state_d = SHOW_A;
        SHOW_A:  state_d = BLANK_B;
        BLANK_B: state_d = SHOW_B;
        SHOW_B:  state_d = BLANK_A;
`else
        SHOW_A:  state_d = SHOW_B;
        SHOW_B:  state_d = SHOW_A;
`endif
        default: state_d = RST_STATE;
      endcase
    end
  end

  // select follows state only, so it stays put while en=0 darkens the anodes
  always_comb begin
    bus.select       = ((state_q == BLANK_A) || (state_q == SHOW_A)) ? SEL_SWITCH1 : SEL_SWITCH2;
    bus.anode_a_n    = !(bus.en && (state_q == SHOW_A));
    bus.anode_b_n    = !(bus.en && (state_q == SHOW_B));
    bus.digit_strobe = bus.en && show && cnt_zero;
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl; the reference model tracks a
// position within the scan period and derives outputs from the interval boundaries.
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int B = 2;
`ifdef BLANK_EN
  localparam int PERIOD = 2 * (D + B);
`else
  localparam int PERIOD = 2 * D;
`endif
  localparam int N_CYCLES = 2000;

  logic clk;
  logic reset;

  seg_scan_ctrl_if u_if ();

  seg_scan_ctrl #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B),
    .CNT_W        (17)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_q[$];
  int         vectors;
  int         miscompares;
  logic [3:0] mux_out;

  // {select, anode_a_n, anode_b_n, digit_strobe} for a period position
  function automatic logic [3:0] model(input int p, input logic en);
    logic sel, lit_a, lit_b, first;
`ifdef BLANK_EN
    sel   = (p < B + D);
    lit_a = (p >= B) && (p < B + D);
    lit_b = (p >= 2 * B + D);
    first = (p == B) || (p == 2 * B + D);
`else
    sel   = (p < D);
    lit_a = (p < D);
    lit_b = (p >= D);
    first = (p == 0) || (p == D);
`endif
    return {sel, !(en && lit_a), !(en && lit_b), en && first};
  endfunction

  initial begin
    int p;
    reset    = 1'b0;
    u_if.en  = 1'b0;
    p        = 0;
    for (int c = 0; c < N_CYCLES; c++) begin
      @(posedge clk);
      if (!reset)       p = 0;
      else if (u_if.en) p = (p + 1) % PERIOD;
      #1;
      if (c < 3) begin
        reset   = 1'b0;
        u_if.en = 1'b1;
      end else if (c < 60) begin
        reset   = 1'b1;
        u_if.en = 1'b1;
      end else begin
        reset   = ($urandom_range(0, 99) >= 3);
        u_if.en = ($urandom_range(0, 99) < 75);
      end
      exp_q.push_back(model(p, u_if.en));
    end
    for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [3:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {u_if.select, u_if.anode_a_n, u_if.anode_b_n, u_if.digit_strobe};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL outputs @%0t: got sel/an_a/an_b/stb=%b required %b", $time, act_v, exp_v);
      end
      vectors++;
      if (!(u_if.anode_a_n | u_if.anode_b_n)) begin
        miscompares++;
        $display("FAIL anode_excl @%0t: got both anodes low, required at most one", $time);
      end
      mux_out = u_if.select ? 4'hA : 4'h3;
      if (!u_if.anode_a_n || !u_if.anode_b_n) begin
        vectors++;
        if (mux_out !== (!u_if.anode_a_n ? 4'hA : 4'h3)) begin
          miscompares++;
          $display("FAIL mux_digit @%0t: got %h required %h", $time, mux_out,
                   (!u_if.anode_a_n ? 4'hA : 4'h3));
        end
      end
    end
  end

endmodule

`default_nettype wire
